// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32 core slice.
//   addr_p       : data-memory word-address width
//   data_width_p : data word width (the load/store path supports 32 only)
//   byte_addr_p  : byte-address width seen by the load/store unit
//   mem_size_e   : access size encoding carried on the request bus
//   lsu_state_e  : load/store controller states
//   access_err() : size/alignment legality check for a request
package riscv_pkg;

  localparam int addr_p       = 10;
  localparam int data_width_p = 32;
  localparam int byte_addr_p  = addr_p + 2;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    CAP  = 2'b10,
    WR   = 2'b11
  } lsu_state_e;

  // Error when the access is misaligned for its size, or the size code is 11.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = lane[0];
      SIZE_W:  err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for sub-word accesses.
//   size_i     : access size (mem_size_e encoding)
//   unsigned_i : zero-extend byte/half loads instead of sign-extending
//   lane_i     : byte offset within the word (addr[1:0])
//   raw_i      : word read from memory
//   wdata_i    : right-justified store data
//   load_o     : extracted and extended load result
//   merge_o    : raw_i with only the addressed lane replaced by store data
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] raw_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[{lane_i, 3'b000} +: 8];
    half_sel = raw_i[{lane_i[1], 4'b0000} +: 16];
    load_o   = raw_i;
    merge_o  = wdata_i;
    case (size_i)
      SIZE_B: begin
        load_o  = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
        merge_o = raw_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_o  = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        merge_o = raw_i;
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = raw_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store controller in front of a word-addressed,
// single-port memory with registered read data and no byte enables.
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   req_*                    : request from the pipeline (valid/ready)
//   rsp_valid_o/rdata/err    : one-cycle registered response pulse
//   mem_addr_o/rd_en/wr_en   : memory word address and strobes
//   mem_data_o / mem_data_i  : memory write data / read data (1 cycle after rd_en)
//   dbg_state_o              : current controller state
//
// Handshake: a request transfers on the rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only in IDLE and out of reset.
// Responses have no backpressure: rsp_valid_o pulses for exactly one cycle.
//
// Flows: load IDLE-RD-CAP-IDLE, word store IDLE-WR-IDLE, sub-word store
// IDLE-RD-CAP-WR-IDLE (read-modify-write), bad request answered from IDLE.
module lsu_mem_ctrl
  import riscv_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_unsigned_i,
  input  logic [byte_addr_p-1:0] req_addr_i,
  input  logic [31:0]            req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [addr_p-1:0]      mem_addr_o,
  output logic                   mem_rd_en_o,
  output logic                   mem_wr_en_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i,
  output lsu_state_e             dbg_state_o
);

  lsu_state_e             state_q, state_d;
  logic                   we_q, uns_q;
  logic [1:0]             size_q;
  logic [byte_addr_p-1:0] addr_q;
  logic [31:0]            wdata_q, merged_q, wr_data_q;
  logic                   rsp_valid_q, rsp_err_q;
  logic [31:0]            rsp_rdata_q;
  logic                   accept, req_err;
  logic [31:0]            load_ext, merge_word, wr_word;

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .lane_i     (addr_q[1:0]),
    .raw_i      (mem_data_i),
    .wdata_i    (wdata_q),
    .load_o     (load_ext),
    .merge_o    (merge_word)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_o = rstn_i && (state_q == IDLE);
    accept      = req_valid_i && req_ready_o;
    req_err     = access_err(req_size_i, req_addr_i[1:0]);
    // Word stores skip the read; sub-word stores read first to merge.
    wr_word     = (size_q == SIZE_W) ? wdata_q : merged_q;

    case (state_q)
      IDLE: if (accept && !req_err) state_d = (req_we_i && req_size_i == SIZE_W) ? WR : RD;
      RD:   state_d = CAP;
      CAP:  state_d = we_q ? WR : IDLE;
      WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_rd_en_o = (state_q == RD);
    mem_wr_en_o = (state_q == WR);
    mem_addr_o  = addr_q[byte_addr_p-1:2];
    // Write data is live in WR and otherwise holds the last word written.
    mem_data_o  = (state_q == WR) ? wr_word : wr_data_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      merged_q    <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;

      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        if (req_err) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
      end

      if (state_q == CAP) begin
        merged_q <= merge_word;
        if (!we_q) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_ext;
        end
      end

      if (state_q == WR) begin
        wr_data_q   <= wr_word;
        rsp_valid_q <= 1'b1;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [11:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [9:0]  mem_addr_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  lsu_state_e  dbg_state;

  lsu_mem_ctrl dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .dbg_state_o    (dbg_state)
  );

  // Memory under the controller: registered read, plain word write.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [31:0] mem_rdata = 32'h0;
  always @(posedge clk_i) begin
    if (mem_wr_en_o) mem[mem_addr_o] <= mem_data_o;
    if (mem_rd_en_o) mem_rdata <= mem[mem_addr_o];
  end
  assign mem_data_i = mem_rdata;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:1023];
  int checks = 0;
  int errors = 0;
  int rd_exp = 0;
  int rd_seen = 0;

  logic [32:0] exp_q[$];      // {err, rdata}
  int          exp_cyc_q[$];
  logic [41:0] wr_exp_q[$];   // {word addr, data}
  int          wr_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_bad(input logic [1:0] size, input int off);
    return (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input int off);
    int unsigned v;
    if (size == 2'd2) return word;
    if (size == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [31:0] wdata, input int off);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wdata;
    sh   = (size == 2'd0) ? 8 * off : 16 * (off / 2);
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((wdata << sh) & mask);
  endfunction

  // ---------------- driver ----------------
  // Called and returns at a falling edge; leaves req_valid_i high so
  // consecutive calls form a back-to-back stream.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata, input bit abort);
    int acc, waited, w, off;
    logic [31:0] nw;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    waited = 0;
    while (!req_ready_o && waited < 40) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready got 0 expected 1 (cycle %0d)", cyc);
      req_valid_i = 1'b0;
      return;
    end
    acc = cyc;
    w   = int'(addr) / 4;
    off = int'(addr) % 4;
    if (model_bad(size, off)) begin
      exp_q.push_back({1'b1, 32'h0});
      exp_cyc_q.push_back(acc + 1);
    end else if (!we) begin
      rd_exp++;
      exp_q.push_back({1'b0, model_load(ref_mem[w], size, uns, off)});
      exp_cyc_q.push_back(acc + 3);
    end else if (size == 2'd2) begin
      ref_mem[w] = wdata;
      wr_exp_q.push_back({w[9:0], wdata});
      wr_cyc_q.push_back(acc + 1);
      exp_q.push_back({1'b0, 32'h0});
      exp_cyc_q.push_back(acc + 2);
    end else begin
      rd_exp++;
      if (!abort) begin
        nw = model_store(ref_mem[w], size, wdata, off);
        ref_mem[w] = nw;
        wr_exp_q.push_back({w[9:0], nw});
        wr_cyc_q.push_back(acc + 3);
        exp_q.push_back({1'b0, 32'h0});
        exp_cyc_q.push_back(acc + 4);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (mem_rd_en_o && mem_wr_en_o) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: rd_en and wr_en both 1 (cycle %0d)", cyc);
      end
      if (mem_rd_en_o) rd_seen++;
      if (mem_wr_en_o) begin
        if (wr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h expected none (cycle %0d)", mem_addr_o, mem_data_o, cyc);
        end else begin
          check("wr_addr", mem_addr_o, wr_exp_q[0][41:32]);
          check("wr_data", mem_data_o, wr_exp_q[0][31:0]);
          check("wr_cycle", cyc, wr_cyc_q[0]);
          void'(wr_exp_q.pop_front());
          void'(wr_cyc_q.pop_front());
        end
      end else if (wr_cyc_q.size() != 0 && cyc > wr_cyc_q[0]) begin
        checks++; errors++;
        $display("FAIL missing_write: got none expected at cycle %0d", wr_cyc_q[0]);
        void'(wr_exp_q.pop_front());
        void'(wr_cyc_q.pop_front());
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: rdata %0h err %0b expected none (cycle %0d)", rsp_rdata_o, rsp_err_o, cyc);
        end else begin
          check("rsp_err", rsp_err_o, exp_q[0][32]);
          check("rsp_rdata", rsp_rdata_o, exp_q[0][31:0]);
          check("rsp_cycle", cyc, exp_cyc_q[0]);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end else if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
        checks++; errors++;
        $display("FAIL missing_rsp: got none expected at cycle %0d", exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk_i);

    check("reset_ready", req_ready_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_rsp_rdata", rsp_rdata_o, 0);
    check("reset_rsp_err", rsp_err_o, 0);
    check("reset_rd_en", mem_rd_en_o, 0);
    check("reset_wr_en", mem_wr_en_o, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_mem_data", mem_data_o, 0);

    rstn_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", req_ready_o, 1);

    // word store then word load
    issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0);
    // extension cases
    issue(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 12'h010, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 12'h012, 32'h0, 1'b0);
    idle(2);
    // read-modify-write
    issue(1'b1, 2'd0, 1'b0, 12'h011, 32'h0000005A, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 12'h012, 32'h00001234, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0);
    idle(2);
    // bad requests, then confirm memory untouched
    issue(1'b0, 2'd2, 1'b0, 12'h011, 32'h0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 12'h013, 32'hFFFF, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 12'h010, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0);
    idle(3);
    // three loads held back-to-back
    issue(1'b0, 2'd0, 1'b0, 12'h010, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 12'h012, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0);
    idle(3);

    // randomized traffic over a small address window
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      issue(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 127)), $urandom, 1'b0);
    end
    idle(8);

    // reset during the write phase of a sub-word store
    issue(1'b1, 2'd0, 1'b0, 12'h021, 32'h000000A5, 1'b1);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check("abort_wr_en_before", mem_wr_en_o, 1);
    rstn_i = 1'b0;
    #1;
    check("abort_wr_en_dropped", mem_wr_en_o, 0);
    check("abort_ready_low", req_ready_o, 0);
    @(negedge clk_i);
    check("abort_no_rsp", rsp_valid_o, 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_abort", req_ready_o, 1);
    issue(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 1'b0);
    idle(10);

    check("rsp_queue_drained", exp_q.size(), 0);
    check("wr_queue_drained", wr_exp_q.size(), 0);
    check("read_strobe_count", rd_seen, rd_exp);
    for (int i = 0; i < 32; i++) check("mem_contents", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
